// File: rtl/tdm_demux16.sv
// Serial-to-parallel TDM demultiplexer: rebuilds an N-bit frame from a slot-ordered
// serial stream, aligned by a frame-sync strobe, with frame-valid and misalignment pulses.
module tdm_demux16 #(
  parameter int unsigned N  = 16,
  parameter int unsigned SW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  input  logic          sync,
  output logic [N-1:0]  frame,
  output logic          frame_valid,
  output logic [SW-1:0] slot,
  output logic          frame_err,
  output logic          locked
);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  localparam logic [SW-1:0] LastSlot = SW'(N - 1);

  state_e        state_q, state_d;
  logic [N-1:0]  data_q, data_d;
  logic [N-1:0]  frame_q, frame_d;
  logic [SW-1:0] slot_q, slot_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          locked_q, locked_d;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      data_q        <= '0;
      frame_q       <= '0;
      slot_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      frame_q       <= frame_d;
      slot_q        <= slot_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      locked_q      <= locked_d;
    end
  end

  // Next-state: slot bookkeeping, frame completion and resync handling
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    frame_d       = frame_q;
    slot_d        = slot_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    if (din_valid) begin
      if (state_q == IDLE) begin
        if (sync) begin
          data_d[0] = din;
          slot_d    = SW'(1);
          state_d   = COLLECT;
        end
      end else if (sync && (slot_q != '0)) begin
        // Misaligned sync: drop the partial frame and restart at slot 1
        frame_err_d = 1'b1;
        data_d[0]   = din;
        slot_d      = SW'(1);
      end else begin
        data_d[slot_q] = din;
        slot_d         = slot_q + SW'(1);
        if (slot_q == LastSlot) begin
          frame_d       = {din, data_q[N-2:0]};
          frame_valid_d = 1'b1;
        end
      end
    end

    locked_d = (state_d == COLLECT);
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign frame_err   = frame_err_q;
  assign locked      = locked_q;

endmodule
